// File: rtl/bcd_adder_seq.sv
// Digit-serial BCD adder/subtractor: one decimal digit per clock, valid/ready on both sides.
// Subtraction adds the nine's complement of B with an inverted borrow as the carry chain.
module bcd_adder_seq #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   input  logic                  cin,
   input  logic                  sub,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   s,
   output logic                  cout,
   output logic                  err,
   output logic                  busy
);

   localparam int W     = 4 * DIGITS;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Returns {carry_out, digit} for one BCD digit position.
   function automatic logic [4:0] bcd_digit(input logic [3:0] a_k,
                                            input logic [3:0] b_k,
                                            input logic       sub_k,
                                            input logic       carry_k);
      logic [3:0] bd;
      logic [4:0] t;
      logic [4:0] t6;
      bd = sub_k ? (4'd9 - b_k) : b_k;
      t  = {1'b0, a_k} + {1'b0, bd} + {4'b0000, carry_k};
      t6 = t + 5'd6;
      if (t > 5'd9) begin
         bcd_digit = {1'b1, t6[3:0]};
      end else begin
         bcd_digit = {1'b0, t[3:0]};
      end
   endfunction

   function automatic logic digit_bad(input logic [3:0] a_k, input logic [3:0] b_k);
      digit_bad = (a_k > 4'd9) || (b_k > 4'd9);
   endfunction

   state_t             r_state;
   state_t             w_state_nxt;
   logic [W-1:0]       r_a;
   logic [W-1:0]       r_b;
   logic [W-1:0]       r_acc;
   logic [W-1:0]       r_s;
   logic               r_sub;
   logic               r_carry;
   logic               r_flag;
   logic               r_cout;
   logic               r_err;
   logic               r_in_ready;
   logic               r_out_valid;
   logic               r_busy;
   logic [IDX_W-1:0]   r_idx;

   logic               w_accept;
   logic               w_last;
   logic [4:0]         w_dig_res;
   logic               w_dig_err;
   logic [W-1:0]       w_acc_nxt;

   assign w_accept  = (r_state == ST_IDLE) && r_in_ready && in_valid;
   assign w_last    = (r_idx == IDX_W'(DIGITS - 1));
   assign w_dig_res = bcd_digit(r_a[3:0], r_b[3:0], r_sub, r_carry);
   assign w_dig_err = digit_bad(r_a[3:0], r_b[3:0]);
   // New digit enters at the top so digit 0 lands at the bottom after DIGITS shifts.
   assign w_acc_nxt = (r_acc >> 4) | (W'(w_dig_res[3:0]) << (W - 4));

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (w_last) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_DONE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register and handshake/status flags, registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= (w_state_nxt == ST_IDLE);
         r_out_valid <= (w_state_nxt == ST_DONE);
         r_busy      <= (w_state_nxt != ST_IDLE);
      end
   end

   // Operand capture, digit-serial datapath and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
         r_s     <= '0;
         r_sub   <= 1'b0;
         r_carry <= 1'b0;
         r_flag  <= 1'b0;
         r_cout  <= 1'b0;
         r_err   <= 1'b0;
         r_idx   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_sub   <= sub;
                  r_carry <= sub ? ~cin : cin;
                  r_flag  <= 1'b0;
                  r_acc   <= '0;
                  r_idx   <= '0;
               end
            end
            ST_RUN: begin
               r_a     <= r_a >> 4;
               r_b     <= r_b >> 4;
               r_carry <= w_dig_res[4];
               r_flag  <= r_flag | w_dig_err;
               r_acc   <= w_acc_nxt;
               if (w_last) begin
                  r_idx  <= '0;
                  r_s    <= w_acc_nxt;
                  r_cout <= r_sub ? ~w_dig_res[4] : w_dig_res[4];
                  r_err  <= r_flag | w_dig_err;
               end else begin
                  r_idx  <= r_idx + IDX_W'(1);
               end
            end
            default: begin
               r_idx <= r_idx;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign s         = r_s;
   assign cout      = r_cout;
   assign err       = r_err;

endmodule

// File: tb/tb_bcd_adder_seq.sv
// Self-checking bench for bcd_adder_seq (DIGITS=4): directed table, handshake/reset
// sequences, throughput, and random operations against a decimal-arithmetic model.
module tb_bcd_adder_seq;

   localparam int DIGITS = 4;
   localparam int W      = 4 * DIGITS;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          cin = 1'b0;
   logic          sub = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  s;
   logic          cout;
   logic          err;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   bcd_adder_seq #(.DIGITS(DIGITS)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .s(s), .cout(cout), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      logic [15:0] s;
      logic        cout;
      logic        err;
   } vec_t;

   vec_t vt[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Decimal reference: convert digits to integers, do the arithmetic, convert back.
   function automatic void ref_model(input logic [15:0] av, input logic [15:0] bv,
                                     input logic ci, input logic su,
                                     output logic [15:0] so, output logic co, output logic eo);
      int ad, bd, r, p;
      ad = 0; bd = 0; p = 1; eo = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (av[4*k +: 4] > 4'd9 || bv[4*k +: 4] > 4'd9) eo = 1'b1;
         ad += int'(av[4*k +: 4]) * p;
         bd += int'(bv[4*k +: 4]) * p;
         p  *= 10;
      end
      if (!su) begin
         r  = ad + bd + int'(ci);
         co = (r >= 10000);
         if (co) r -= 10000;
      end else begin
         r  = ad - bd - int'(ci);
         co = (r < 0);
         if (co) r += 10000;
      end
      so = '0;
      for (int k = 0; k < DIGITS; k++) begin
         so[4*k +: 4] = 4'(r % 10);
         r = r / 10;
      end
   endfunction

   // Waits for in_ready, presents one operand set, returns just after the accept edge.
   task automatic start_op(input logic [15:0] av, input logic [15:0] bv,
                           input logic ci, input logic su);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 20) check("ready_wait", in_ready, 1);
      a = av; b = bv; cin = ci; sub = su; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
   endtask

   // Latency counts the accept edge as edge 1.
   task automatic wait_done(output int lat);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 30) begin
         @(posedge clk); #1; lat++;
      end
   endtask

   initial begin
      int lat, seen, nacc;
      int acc_cyc[$];
      logic [15:0] es, ra, rb;
      logic ec, ee, rci, rsu, bad;

      vt[0] = '{16'h0049, 16'h0049, 1'b0, 1'b0, 16'h0098, 1'b0, 1'b0};
      vt[1] = '{16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vt[2] = '{16'h0007, 16'h0004, 1'b1, 1'b0, 16'h0012, 1'b0, 1'b0};
      vt[3] = '{16'h0100, 16'h0001, 1'b0, 1'b1, 16'h0099, 1'b0, 1'b0};
      vt[4] = '{16'h0001, 16'h0002, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0};
      vt[5] = '{16'h000A, 16'h0001, 1'b0, 1'b0, 16'h0011, 1'b0, 1'b1};
      vt[6] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
      vt[7] = '{16'h5000, 16'h4999, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};

      // Reset state
      #2 rst_n = 1'b0;
      #1;
      check("rst_s", s, 0);
      check("rst_cout", cout, 0);
      check("rst_err", err, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
      repeat (2) @(posedge clk);
      #1 check("rst_in_ready_held", in_ready, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_in_ready", in_ready, 1);
      check("post_rst_busy", busy, 0);

      // Directed table
      for (int i = 0; i < 8; i++) begin
         start_op(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub);
         check($sformatf("vec%0d_busy_run", i), busy, 1);
         wait_done(lat);
         check($sformatf("vec%0d_out_valid", i), out_valid, 1);
         check($sformatf("vec%0d_latency", i), lat, 5);
         check($sformatf("vec%0d_s", i), s, vt[i].s);
         check($sformatf("vec%0d_cout", i), cout, vt[i].cout);
         check($sformatf("vec%0d_err", i), err, vt[i].err);
         check($sformatf("vec%0d_in_ready_done", i), in_ready, 0);
         @(posedge clk); #1;
         check($sformatf("vec%0d_valid_drop", i), out_valid, 0);
         check($sformatf("vec%0d_s_kept", i), s, vt[i].s);
         check($sformatf("vec%0d_in_ready_idle", i), in_ready, 1);
      end

      // Back-pressure in DONE
      out_ready = 1'b0;
      start_op(16'h2468, 16'h1357, 1'b0, 1'b0);
      wait_done(lat);
      check("hold_latency", lat, 5);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check($sformatf("hold%0d_out_valid", k), out_valid, 1);
         check($sformatf("hold%0d_s", k), s, 16'h3825);
         check($sformatf("hold%0d_cout", k), cout, 0);
         check($sformatf("hold%0d_in_ready", k), in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("hold_release_valid", out_valid, 0);
      check("hold_release_ready", in_ready, 1);

      // Reset in the second RUN cycle
      start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("abort_s", s, 0);
      check("abort_cout", cout, 0);
      check("abort_err", err, 0);
      check("abort_out_valid", out_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_in_ready", in_ready, 0);
      @(negedge clk) rst_n = 1'b1;
      seen = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      check("abort_no_valid", seen, 0);
      check("abort_ready_back", in_ready, 1);
      start_op(16'h0049, 16'h0049, 1'b0, 1'b0);
      wait_done(lat);
      check("abort_next_latency", lat, 5);
      check("abort_next_s", s, 16'h0098);
      @(posedge clk); #1;

      // Throughput with in_valid and out_ready held high
      a = 16'h0049; b = 16'h0049; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      repeat (20) begin
         if (in_ready) acc_cyc.push_back(cyc);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      nacc = acc_cyc.size();
      check("thr_accepts", (nacc >= 3) ? 1 : 0, 1);
      if (nacc >= 3) begin
         check("thr_gap0", acc_cyc[1] - acc_cyc[0], 6);
         check("thr_gap1", acc_cyc[2] - acc_cyc[1], 6);
      end
      repeat (8) @(posedge clk);
      #1;

      // Random operations against the reference model
      for (int n = 0; n < 60; n++) begin
         ra = '0; rb = '0;
         for (int k = 0; k < DIGITS; k++) begin
            ra[4*k +: 4] = 4'($urandom_range(0, 9));
            rb[4*k +: 4] = 4'($urandom_range(0, 9));
         end
         bad = ($urandom_range(0, 9) == 0);
         if (bad) begin
            if ($urandom_range(0, 1) == 0) ra[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
            else                           rb[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
         end
         rci = 1'($urandom);
         rsu = 1'($urandom);
         ref_model(ra, rb, rci, rsu, es, ec, ee);
         out_ready = ($urandom_range(0, 3) != 0);
         start_op(ra, rb, rci, rsu);
         wait_done(lat);
         check($sformatf("rnd%0d_latency", n), lat, 5);
         check($sformatf("rnd%0d_err", n), err, ee);
         if (!ee) begin
            check($sformatf("rnd%0d_s", n), s, es);
            check($sformatf("rnd%0d_cout", n), cout, ec);
         end
         if (!out_ready) begin
            repeat ($urandom_range(1, 3)) begin
               @(posedge clk); #1;
               check($sformatf("rnd%0d_stall_valid", n), out_valid, 1);
            end
            out_ready = 1'b1;
         end
         @(posedge clk); #1;
         check($sformatf("rnd%0d_valid_drop", n), out_valid, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_adder_seq.md
BCD_ADDER_SEQ -- requirements
Module: bcd_adder_seq

Interface
REQ-001 Parameter DIGITS, default 4, number of BCD digits per operand; legal range 1..16.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand set present on a, b, cin, sub.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 a  input  4*DIGITS  operand A; digit k is a[4k+3:4k], and digit 0 is least significant.
REQ-007 b  input  4*DIGITS  operand B, with the same packing as a.
REQ-008 cin  input  1  carry-in when sub=0, borrow-in when sub=1.
REQ-009 sub  input  1  0 selects A+B+cin, 1 selects A-B-cin.
REQ-010 out_valid  output  1  result present on s, cout, err.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 s  output  4*DIGITS  BCD result.
REQ-013 cout  output  1  carry-out when sub=0, borrow-out when sub=1.
REQ-014 err  output  1  at least one input digit was greater than 9.
REQ-015 busy  output  1  state is not IDLE.

Function
REQ-016 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-017 IDLE: in_ready=1; when in_valid=1, the block SHALL latch a, b, sub, set digit index 0, set the internal carry to (sub ? ~cin : cin), clear the error flag, and go to RUN.
REQ-018 RUN SHALL process exactly one digit per cycle, starting at digit 0 and ending at digit DIGITS-1.
REQ-019 Per-digit datapath: bd = sub ? (9 - b_k) : b_k, 4-bit wrap; t = a_k + bd + carry, 5-bit; if t > 9 then digit = (t + 6) mod 16 and carry = 1, else digit = t and carry = 0.
REQ-020 The error flag SHALL become 1 if a_k > 9 or b_k > 9 for any digit, and SHALL stay 1 until the next accept; computation continues unchanged when the flag is set.
REQ-021 After digit DIGITS-1 the block SHALL load s from the digit results, set cout = (sub ? ~carry : carry), set err from the flag, and go to DONE.
REQ-022 out_valid SHALL rise exactly DIGITS+1 clock edges after the accept edge.
REQ-023 DONE: out_valid=1 and in_ready=0; s, cout and err SHALL hold stable until out_ready=1, after which the next state is IDLE.
REQ-024 in_ready SHALL be 0 in RUN and DONE; in_valid is ignored outside IDLE, so an accept and a completion can never occur in the same cycle.
REQ-025 s, cout and err SHALL keep the last result after the handshake and SHALL change only when the next result is loaded.
REQ-026 With out_ready held at 1, throughput SHALL be one operation per DIGITS+2 cycles (IDLE, DIGITS RUN cycles, DONE).
REQ-027 Subtraction with a borrow SHALL produce the ten's complement in s, with cout=1 (example: 0001-0002 gives s=9999).
REQ-028 Changes to a, b, cin or sub after the accept SHALL NOT affect the operation in progress.

Reset
REQ-029 When rst_n=0, the block SHALL asynchronously enter IDLE and force s=0, cout=0, err=0, out_valid=0, busy=0, carry=0 and digit index 0.
REQ-030 in_ready SHALL be 0 while rst_n=0, and SHALL be 1 from the first clock edge after rst_n deasserts.
REQ-031 A reset during RUN or DONE SHALL abort the operation and discard its result; no out_valid pulse SHALL follow.

Verification (DIGITS=4, values in hex/BCD)
REQ-032 a=0049, b=0049, cin=0, sub=0 -> s=0098, cout=0, err=0, with out_valid exactly 5 edges after accept.
REQ-033 Add checks: a=9999, b=0001, cin=0 -> s=0000, cout=1; a=0007, b=0004, cin=1 -> s=0012, cout=0.
REQ-034 Subtract checks: sub=1, a=0100, b=0001, cin=0 -> s=0099, cout=0; sub=1, a=0001, b=0002, cin=0 -> s=9999, cout=1.
REQ-035 a=000A, b=0001 -> err=1 with the output handshake unchanged; the next valid operation returns err=0.
REQ-036 Hold out_ready=0 for 3 cycles in DONE -> s, cout and out_valid stay stable and in_ready stays 0; raising out_ready returns the block to IDLE on the next edge.
REQ-037 Assert rst_n=0 in the second RUN cycle -> all outputs are 0 immediately, with no out_valid afterwards, and a new operation after release completes correctly.
